// File: rtl/dii_package.sv
// Debug interconnect flit type shared by every module on the debug network.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_trace_package.sv
// Trace packet format shared by osd_trace_packetization and osd_trace_depacketization.
package osd_trace_package;

  localparam int WORD_DEST    = 0;
  localparam int WORD_SRC     = 1;
  localparam int WORD_FLAGS   = 2;
  localparam int WORD_PAYLOAD = 3;

  localparam logic [1:0] TYPE_EVENT = 2'b10;
  localparam int OVERFLOW_BIT = 0;

  typedef enum logic [2:0] {
    ST_DEST,
    ST_SRC,
    ST_FLAGS,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_OUT
  } depkt_state_e;

  // Number of 16-bit payload words needed to carry a width-bit event.
  function automatic int payload_words(input int width);
    return (width + 15) / 16;
  endfunction

endpackage

// File: rtl/osd_trace_depacketization.sv
// Receives DII trace-event packets addressed to this module and reassembles
// each payload into one trace event presented on a valid/ready interface.
module osd_trace_depacketization
  import dii_package::*;
#(
  parameter int         WIDTH      = 112,
  parameter logic [1:0] TYPE_EVENT = osd_trace_package::TYPE_EVENT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        id,
  input  dii_flit           debug_in,
  output logic              debug_in_ready,
  output logic [WIDTH-1:0]  trace_data,
  output logic [15:0]       trace_src,
  output logic              trace_overflow,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [15:0]       drop_count
);

  localparam int NW = osd_trace_package::payload_words(WIDTH);
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] NW_C = CW'(NW);

  osd_trace_package::depkt_state_e state, state_next;

  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shadow_data, shadow_next;
  logic [15:0]      shadow_src, src_next;
  logic             shadow_ovf, ovf_next;
  logic             drop;
  logic             load_out;
  logic             xfer;

  assign debug_in_ready = (state != osd_trace_package::ST_OUT);
  assign xfer           = debug_in.valid && debug_in_ready;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shadow_next = shadow_data;
    src_next    = shadow_src;
    ovf_next    = shadow_ovf;
    drop        = 1'b0;
    load_out    = 1'b0;

    case (state)
      osd_trace_package::ST_DEST: begin
        if (xfer) begin
          if (debug_in.last) begin
            drop = 1'b1;
          end else if (debug_in.data != {6'b0, id}) begin
            drop       = 1'b1;
            state_next = osd_trace_package::ST_DRAIN;
          end else begin
            state_next = osd_trace_package::ST_SRC;
          end
        end
      end

      osd_trace_package::ST_SRC: begin
        if (xfer) begin
          src_next = debug_in.data;
          if (debug_in.last) begin
            drop       = 1'b1;
            state_next = osd_trace_package::ST_DEST;
          end else begin
            state_next = osd_trace_package::ST_FLAGS;
          end
        end
      end

      osd_trace_package::ST_FLAGS: begin
        if (xfer) begin
          if (debug_in.data[15:14] != TYPE_EVENT) begin
            drop       = 1'b1;
            state_next = debug_in.last ? osd_trace_package::ST_DEST
                                       : osd_trace_package::ST_DRAIN;
          end else if (debug_in.last) begin
            drop       = 1'b1;
            state_next = osd_trace_package::ST_DEST;
          end else begin
            ovf_next   = debug_in.data[osd_trace_package::OVERFLOW_BIT];
            cnt_next   = '0;
            state_next = osd_trace_package::ST_PAYLOAD;
          end
        end
      end

      osd_trace_package::ST_PAYLOAD: begin
        if (xfer) begin
          if (cnt == NW_C) begin
            drop       = 1'b1;
            state_next = debug_in.last ? osd_trace_package::ST_DEST
                                       : osd_trace_package::ST_DRAIN;
          end else begin
            // Bits of the top word that fall at or above WIDTH are discarded.
            for (int b = 0; b < 16; b++) begin
              if (16 * int'(cnt) + b < WIDTH)
                shadow_next[16 * int'(cnt) + b] = debug_in.data[b];
            end
            cnt_next = cnt + 1'b1;
            if (debug_in.last) begin
              if (cnt + 1'b1 == NW_C) begin
                load_out   = 1'b1;
                state_next = osd_trace_package::ST_OUT;
              end else begin
                drop       = 1'b1;
                state_next = osd_trace_package::ST_DEST;
              end
            end
          end
        end
      end

      osd_trace_package::ST_DRAIN: begin
        if (xfer && debug_in.last)
          state_next = osd_trace_package::ST_DEST;
      end

      osd_trace_package::ST_OUT: begin
        if (trace_ready)
          state_next = osd_trace_package::ST_DEST;
      end

      default: state_next = osd_trace_package::ST_DEST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= osd_trace_package::ST_DEST;
      cnt         <= '0;
      shadow_data <= '0;
      shadow_src  <= '0;
      shadow_ovf  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      shadow_data <= shadow_next;
      shadow_src  <= src_next;
      shadow_ovf  <= ovf_next;
    end
  end

  // The final payload word is merged in combinationally so the event leaves on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_data     <= '0;
      trace_src      <= '0;
      trace_overflow <= 1'b0;
      trace_valid    <= 1'b0;
    end else if (load_out) begin
      trace_data     <= shadow_next;
      trace_src      <= shadow_src;
      trace_overflow <= shadow_ovf;
      trace_valid    <= 1'b1;
    end else if (state == osd_trace_package::ST_OUT && trace_ready) begin
      trace_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end

endmodule

// File: doc/osd_trace_depacketization.md
Name: osd_trace_depacketization

Overview:
Receive side of the trace packet protocol. Accepts DII trace-event packets addressed to this module and reassembles each payload into one WIDTH-bit event with its overflow flag. Presents the event on a valid/ready trace interface. Sits behind the debug interconnect on a host-side or loopback trace sink, and mirrors osd_trace_packetization field-for-field.

Parameters:
WIDTH, 112, event width in bits (32 timestamp + 16 id + 64 value); payload words NW = (WIDTH+15)/16, default 7
TYPE_EVENT, 2'b10, required value of header word 2, bits [15:14]

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
id  in  10  own module address; match requires dest word == {6'b0,id}
debug_in  in  dii_flit  incoming flit (valid, last, data[15:0])
debug_in_ready  out  1  flit accept
trace_data  out  WIDTH  reassembled event
trace_src  out  16  source word of the delivered packet
trace_overflow  out  1  header word 2, bit 0, of the delivered packet
trace_valid  out  1  event available
trace_ready  in  1  consumer accept
drop_count  out  16  saturating count of discarded packets

Behaviour:
- Reset values: trace_valid=0, trace_data=0, trace_src=0, trace_overflow=0, drop_count=0, FSM=DEST, word counter=0.
- A flit transfers when debug_in.valid && debug_in_ready.
- debug_in_ready=1 in every state except OUT.
- Packet format, one 16-bit word per flit:
  - w0 = dest
  - w1 = src
  - w2 = flags; [15:14] type, [0] overflow
  - w3..w(2+NW) = payload, least-significant word first
  - last is set on the final flit only.
- FSM states: DEST, SRC, FLAGS, PAYLOAD, DRAIN, OUT.
- DEST:
  - Accepted flit with last=1 -> drop, stay in DEST.
  - dest != {6'b0,id} -> drop, go to DRAIN.
  - Otherwise go to SRC.
- SRC:
  - Latch src into a shadow register; go to FLAGS.
  - last=1 -> drop, go to DEST.
- FLAGS:
  - type != TYPE_EVENT -> drop, go to DRAIN (or to DEST if last=1).
  - Otherwise latch bit 0, clear the word counter, go to PAYLOAD.
  - last=1 here with a valid type -> drop (empty payload), go to DEST.
- PAYLOAD:
  - Word k is written to shadow bits [16k+15:16k]; bits at or above WIDTH in the top word are discarded.
  - Counter increments, saturating at NW.
  - last=1 with counter+1 == NW -> copy shadow to outputs, go to OUT.
  - last=1 with counter+1 < NW -> short packet: drop, go to DEST.
  - Flit accepted with counter == NW (extra word) -> long packet: drop; go to DEST if last, else DRAIN.
- DRAIN: accept and discard flits until last=1, then go to DEST.
- OUT:
  - trace_valid=1; trace_data, trace_src and trace_overflow are held stable.
  - On trace_ready, trace_valid=0 on the next edge and go to DEST.
- Latency: trace_valid rises on the first clk edge after the final payload flit is accepted.
- No back-to-back bypass: the header of the next packet is accepted only after OUT exits.
- Every drop increments drop_count exactly once per packet; the count saturates at 16'hFFFF.
- Outputs update only on entry to OUT. Shadow registers may change freely while not in OUT.
- Reset mid-packet: outputs return to reset values immediately (async); any partial packet is lost and not counted.
- A flit arriving while in OUT is not accepted (ready=0). The input must hold it.

Decomposition:
- dii_package: dii_flit type.
- Shared osd_trace_package:
  - header word offsets (DEST=0, SRC=1, FLAGS=2, PAYLOAD=3)
  - TYPE_EVENT
  - overflow bit index (0)
  - helper function for NW
- osd_trace_packetization imports the same package so both ends agree on the format.
- No sub-module: the FSM, shadow registers and counter fit in one module of roughly 200 lines.

Test Plan:
- Good packet, id=10'h005: flits 0005, 0001, 8000, then 1111..7777 with last on 7777, trace_ready=1 -> trace_valid for 1 cycle; trace_data=112'h7777_6666_5555_4444_3333_2222_1111, trace_src=0001, trace_overflow=0, drop_count=0.
- Same packet with flags 8001 and trace_ready held 0 for 5 cycles -> trace_valid high and stable for 6 cycles, debug_in_ready=0 throughout, next packet accepted only afterwards, trace_overflow=1.
- Wrong dest 0006, 5-flit packet -> all flits accepted, no trace_valid, drop_count=1; a following good packet is delivered normally.
- Short packet (6 payload words) then long packet (8 payload words) -> no trace_valid, drop_count=2; FSM back in DEST after each last flit.
- Flags 4000 (wrong type) -> drained, drop_count increments; 1-flit packet (last on dest) -> drop_count increments.
- Assert rst=0 during the 4th payload flit, release it, then send a good packet -> outputs zero during reset, drop_count=0, good packet delivered correctly.
